// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // One buffered fetch: instruction word plus the PC of the following word.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ifq_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Request/acknowledge bus between the prefetch unit and instruction memory.
interface ifetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// DEPTH-entry FIFO of {instruction, pc+4} with push/pop/clear and head read.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  ifq_entry_t             push_data_i,
  input  logic                   pop_i,
  output ifq_entry_t             head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ifq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy next-state; clear wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !clear_i && count_q == CNT_W'(DEPTH)));

  no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && !clear_i && count_q == '0));

endmodule

// File: rtl/ifetch_queue.sv
// Sequential instruction prefetcher with redirect flush and stale-response discard.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                stall,
  ifetch_queue_if.master      mem,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [31:0]         pc4
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      target_q, target_d;

  logic             push, pop, head_valid, has_room;
  ifq_entry_t       head, push_data;
  logic [CNT_W-1:0] count, count_next;
  logic             req;
  logic [31:0]      addr;

  assign push      = (state_q == REQ) && mem.mem_ack && !redirect;
  assign pop       = head_valid && !stall && !redirect;
  assign push_data = '{inst: mem.mem_rdata, pc4: fetch_pc_q + PC_STEP};

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (redirect),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (head_valid),
    .count_o     (count)
  );

  // Occupancy after this edge, used to gate further issue.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
    has_room = (count_next < CNT_W'(DEPTH));
  end

  // State, fetch address and latched redirect target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
    end
  end

  // Next-state and fetch address selection.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = word_align(redirect_pc);
          state_d    = REQ;
        end else if (has_room) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          // An ack in the redirect cycle completes the old request, so the
          // new target can be issued directly without a discard phase.
          if (mem.mem_ack) begin
            fetch_pc_d = word_align(redirect_pc);
          end else begin
            target_d = word_align(redirect_pc);
            state_d  = DISCARD;
          end
        end else if (mem.mem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          if (!has_room) state_d = IDLE;
        end
      end
      DISCARD: begin
        if (redirect) target_d = word_align(redirect_pc);
        if (mem.mem_ack) begin
          fetch_pc_d = redirect ? word_align(redirect_pc) : target_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request and zero-masked decode outputs.
  always_comb begin
    req        = (state_q == REQ) || (state_q == DISCARD);
    addr       = req ? fetch_pc_q : '0;
    inst_valid = head_valid;
    inst       = head_valid ? head.inst : NOP_INST;
    pc4        = head_valid ? head.pc4  : '0;
  end

  assign mem.mem_req  = req;
  assign mem.mem_addr = addr;

endmodule
